// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the Maxnet winner-take-all sequencer.
package maxnet_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StInit,
        StMult,
        StAdd,
        StCheck,
        StUpdate,
        StDone
    } maxnet_state_t;

    localparam int unsigned DefPuLat   = 1;
    localparam int unsigned DefMaxIter = 255;
    localparam int unsigned DefIterW   = 8;

    typedef struct packed {
        logic main_reg_write;
        logic act_write;
        logic mult_write;
        logic add_write;
        logic sel;
        logic busy;
        logic done;
    } maxnet_ctrl_t;

    // Moore output table, indexed by state.
    function automatic maxnet_ctrl_t decode_ctrl(input maxnet_state_t st);
        maxnet_ctrl_t c;
        c = '0;
        c.busy = (st != StIdle);
        unique case (st)
            StIdle:   ;
            StLoad:   c.main_reg_write = 1'b1;
            StInit:   c.act_write = 1'b1;
            StMult:   c.mult_write = 1'b1;
            StAdd:    c.add_write = 1'b1;
            StCheck:  ;
            StUpdate: begin
                c.act_write = 1'b1;
                c.sel       = 1'b1;
            end
            StDone:   c.done = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/maxnet_iter_counter.sv
// Clearable, incrementing pass counter that saturates at its all-ones value.
module maxnet_iter_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {Width{1'b1}})) begin
            count <= count + Width'(1);
        end
    end

endmodule

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the four-lane Maxnet datapath.
// Optional pass limit with timeout: define MAXNET_ITER_LIMIT_EN.
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int unsigned PU_LAT   = DefPuLat,
    parameter int unsigned MAX_ITER = DefMaxIter,
    parameter int unsigned ITER_W   = DefIterW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              found,
    output logic              mainRegWrite,
    output logic              actWrite,
    output logic              multWrite,
    output logic              addWrite,
    output logic              s1,
    output logic              s2,
    output logic              s3,
    output logic              s4,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    localparam int unsigned MultW = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;

`ifdef MAXNET_ITER_LIMIT_EN
    localparam bit LimitEn = 1'b1;
`else
    localparam bit LimitEn = 1'b0;
`endif

    maxnet_state_t state_q, state_d;
    maxnet_ctrl_t  ctrl_q;
    logic [MultW-1:0] mult_cnt_q;
    logic          mult_last;
    logic [ITER_W:0] iter_next;
    logic          limit_hit;

    assign mult_last = (mult_cnt_q == MultW'(PU_LAT - 1));
    assign iter_next = {1'b0, iter_count} + (ITER_W + 1)'(1);
    assign limit_hit = LimitEn && (iter_next == (ITER_W + 1)'(MAX_ITER));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StLoad;
            StLoad:   state_d = StInit;
            StInit:   state_d = StMult;
            StMult:   if (mult_last) state_d = StAdd;
            StAdd:    state_d = StCheck;
            StCheck:  state_d = (found || limit_hit) ? StDone : StUpdate;
            StUpdate: state_d = StMult;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            ctrl_q     <= '0;
            mult_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
            if (state_q == StMult && !mult_last) begin
                mult_cnt_q <= mult_cnt_q + MultW'(1);
            end else begin
                mult_cnt_q <= '0;
            end
        end
    end

    maxnet_iter_counter #(
        .Width (ITER_W)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == StLoad),
        .inc   (state_q == StCheck),
        .count (iter_count)
    );

`ifdef MAXNET_ITER_LIMIT_EN
    logic timeout_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else if (state_q == StLoad) begin
            timeout_q <= 1'b0;
        end else if (state_q == StCheck && !found && limit_hit) begin
            timeout_q <= 1'b1;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign mainRegWrite = ctrl_q.main_reg_write;
    assign actWrite     = ctrl_q.act_write;
    assign multWrite    = ctrl_q.mult_write;
    assign addWrite     = ctrl_q.add_write;
    assign s1           = ctrl_q.sel;
    assign s2           = ctrl_q.sel;
    assign s3           = ctrl_q.sel;
    assign s4           = ctrl_q.sel;
    assign busy         = ctrl_q.busy;
    assign done         = ctrl_q.done;

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller: two instances with different latency/width.
module tb_maxnet_controller;

`ifdef MAXNET_ITER_LIMIT_EN
    localparam bit LimEn = 1'b1;
`else
    localparam bit LimEn = 1'b0;
`endif

    localparam int PhIdle   = 0;
    localparam int PhLoad   = 1;
    localparam int PhInit   = 2;
    localparam int PhMult   = 3;
    localparam int PhAdd    = 4;
    localparam int PhCheck  = 5;
    localparam int PhUpdate = 6;
    localparam int PhDone   = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0, found_a = 1'b0, start_b = 1'b0, found_b = 1'b0;

    logic mrw_a, aw_a, mw_a, adw_a, s1_a, s2_a, s3_a, s4_a, busy_a, done_a, to_a;
    logic mrw_b, aw_b, mw_b, adw_b, s1_b, s2_b, s3_b, s4_b, busy_b, done_b, to_b;
    logic [7:0] iter_a;
    logic [2:0] iter_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    maxnet_controller #(.PU_LAT(1), .MAX_ITER(255), .ITER_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .found(found_a),
        .mainRegWrite(mrw_a), .actWrite(aw_a), .multWrite(mw_a), .addWrite(adw_a),
        .s1(s1_a), .s2(s2_a), .s3(s3_a), .s4(s4_a),
        .busy(busy_a), .done(done_a), .timeout(to_a), .iter_count(iter_a)
    );

    maxnet_controller #(.PU_LAT(2), .MAX_ITER(4), .ITER_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .found(found_b),
        .mainRegWrite(mrw_b), .actWrite(aw_b), .multWrite(mw_b), .addWrite(adw_b),
        .s1(s1_b), .s2(s2_b), .s3(s3_b), .s4(s4_b),
        .busy(busy_b), .done(done_b), .timeout(to_b), .iter_count(iter_b)
    );

    // {mainRegWrite, actWrite, multWrite, addWrite, s4, s3, s2, s1, busy, done}
    function automatic logic [9:0] get_out(input int sel);
        if (sel == 0) return {mrw_a, aw_a, mw_a, adw_a, s4_a, s3_a, s2_a, s1_a, busy_a, done_a};
        return {mrw_b, aw_b, mw_b, adw_b, s4_b, s3_b, s2_b, s1_b, busy_b, done_b};
    endfunction

    function automatic int get_iter(input int sel);
        return (sel == 0) ? int'(iter_a) : int'(iter_b);
    endfunction

    function automatic logic get_to(input int sel);
        return (sel == 0) ? to_a : to_b;
    endfunction

    function automatic logic [9:0] exp_out(input int ph);
        case (ph)
            PhLoad:   return 10'b1000_0000_10;
            PhInit:   return 10'b0100_0000_10;
            PhMult:   return 10'b0010_0000_10;
            PhAdd:    return 10'b0001_0000_10;
            PhCheck:  return 10'b0000_0000_10;
            PhUpdate: return 10'b0100_1111_10;
            PhDone:   return 10'b0000_0000_11;
            default:  return 10'b0000_0000_00;
        endcase
    endfunction

    task automatic set_in(input int sel, input logic st, input logic fd);
        if (sel == 0) begin
            start_a = st;
            found_a = fd;
        end else begin
            start_b = st;
            found_b = fd;
        end
    endtask

    // Caller is at a negedge with the DUT idle; start is sampled at the next posedge.
    // found is 1 only in the CHECK of pass first_hit; it is random noise in all other cycles.
    task automatic do_run(input int sel, input int first_hit, input bit hold_start);
        int sched[$];
        int lat, imax, maxit, passes, nchk, exp_iter;
        bit to;
        logic [9:0] o;
        logic exp_to;
        lat   = (sel == 0) ? 1 : 2;
        imax  = (sel == 0) ? 255 : 7;
        maxit = (sel == 0) ? 255 : 4;
        if (LimEn && first_hit > maxit) begin
            passes = maxit;
            to     = 1'b1;
        end else begin
            passes = first_hit;
            to     = 1'b0;
        end
        sched = {};
        sched.push_back(PhIdle);
        sched.push_back(PhLoad);
        sched.push_back(PhInit);
        for (int p = 1; p <= passes; p++) begin
            if (p > 1) sched.push_back(PhUpdate);
            for (int k = 0; k < lat; k++) sched.push_back(PhMult);
            sched.push_back(PhAdd);
            sched.push_back(PhCheck);
        end
        sched.push_back(PhDone);
        sched.push_back(PhIdle);

        set_in(sel, 1'b1, 1'($urandom_range(0, 1)));
        nchk = 0;
        for (int c = 1; c < sched.size(); c++) begin
            @(negedge clk);
            o = get_out(sel);
            n_tests++;
            if (o !== exp_out(sched[c])) begin
                n_fail++;
                $display("FAIL outputs dut%0d cycle %0d: got %b expected %b", sel, c, o,
                         exp_out(sched[c]));
            end
            if (c >= 2) begin
                exp_iter = (nchk > imax) ? imax : nchk;
                n_tests++;
                if (get_iter(sel) !== exp_iter) begin
                    n_fail++;
                    $display("FAIL iter_count dut%0d cycle %0d: got %0d expected %0d", sel, c,
                             get_iter(sel), exp_iter);
                end
                exp_to = (sched[c] == PhDone || (sched[c] == PhIdle)) ? to : 1'b0;
                n_tests++;
                if (get_to(sel) !== exp_to) begin
                    n_fail++;
                    $display("FAIL timeout dut%0d cycle %0d: got %b expected %b", sel, c,
                             get_to(sel), exp_to);
                end
            end
            if (sched[c] == PhCheck) begin
                nchk++;
                set_in(sel, 1'($urandom_range(0, 1)), (nchk == first_hit));
            end else if (sched[c] == PhIdle) begin
                set_in(sel, hold_start, 1'($urandom_range(0, 1)));
            end else begin
                // start toggles randomly while busy and must be ignored
                set_in(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(0, 1'b1, 1'b1);
        set_in(1, 1'b1, 1'b1);
        repeat (2) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                n_tests++;
                if (get_out(s) !== 10'b0 || get_iter(s) !== 0 || get_to(s) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_state dut%0d: got out=%b iter=%0d to=%b expected 0/0/0",
                             s, get_out(s), get_iter(s), get_to(s));
                end
            end
        end
        set_in(1, 1'b0, 1'b0);
        rst = 1'b1;
        do_run(0, 1, 1'b0);
    endtask

    task automatic test_single_pass();
        do_run(0, 1, 1'b0);
    endtask

    task automatic test_three_pass();
        do_run(1, 3, 1'b0);
    endtask

    task automatic test_limit();
        // Without the limit, 10 passes also exercises saturation of the 3-bit counter.
        do_run(1, LimEn ? 100 : 10, 1'b0);
        do_run(1, 4, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_run(i % 2, int'($urandom_range(1, 6)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_run(0, 2, 1'b1);
        do_run(0, 3, 1'b1);
        do_run(0, 1, 1'b0);
    endtask

    // Reset in the ADD of the second pass (iter_count already 1).
    task automatic test_reset_mid();
        set_in(0, 1'b1, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            set_in(0, 1'b0, 1'b0);
        end
        n_tests++;
        if (get_out(0) !== exp_out(PhAdd) || get_iter(0) !== 1) begin
            n_fail++;
            $display("FAIL pre_reset_add: got out=%b iter=%0d expected %b iter=1", get_out(0),
                     get_iter(0), exp_out(PhAdd));
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (get_out(0) !== 10'b0 || get_iter(0) !== 0 || get_to(0) !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got out=%b iter=%0d to=%b expected 0/0/0", get_out(0),
                     get_iter(0), get_to(0));
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (get_out(0) !== 10'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got out=%b expected 0", get_out(0));
        end
        do_run(0, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_three_pass();
        test_limit();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
